// File: rtl/dma_controller.sv
// -----------------------------------------------------------------------------
// dma_controller
// Single-channel, word-granular memory-to-memory DMA engine.
//
// Slave side (register block at 0x40E0..0x40EF, word access):
//   data_bus_select/addr/mode/write  : register access from the CPU
//   data_bus_read                    : combinational readback (0 unless read)
// Master side:
//   dma_req / dma_grant              : bus request / grant handshake
//   dma_address/mode/reqw/write_data : master cycle, valid only with grant=1
//   dma_read_data                    : read data, valid the cycle after a read
// Interrupt:
//   dma_irq                          : level, DONE & IRQ_EN
// Reset: synchronous active-high 'reset'.
// -----------------------------------------------------------------------------
module dma_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_bus_select,
   input  logic [31:0] data_bus_addr,
   input  logic [1:0]  data_bus_mode,
   input  logic [31:0] data_bus_write,
   output logic [31:0] data_bus_read,
   output logic        dma_req,
   input  logic        dma_grant,
   output logic [31:0] dma_address,
   output logic [1:0]  dma_mode,
   output logic [1:0]  dma_reqw,
   output logic [31:0] dma_write_data,
   input  logic [31:0] dma_read_data,
   output logic        dma_irq
);

   localparam logic [31:0] BASE_ADDR = 32'h0000_40E0;
   localparam logic [1:0]  MODE_NONE = 2'b00;
   localparam logic [1:0]  MODE_RD   = 2'b01;
   localparam logic [1:0]  MODE_WR   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_READ    = 3'd2,
      S_CAPTURE = 3'd3,
      S_WRITE   = 3'd4,
      S_GAP     = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] len_q, len_d;
   logic [31:0] data_q, data_d;
   logic        done_q, done_d;
   logic        irq_en_q, irq_en_d;
   logic        req_q, req_d;
   logic [1:0]  mode_q, mode_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        irq_q, irq_d;

   logic        hit_s, bus_wr_s, bus_rd_s, busy_s, start_s, abort_s, done_sw_s;
   logic [1:0]  reg_sel_s;
   logic [1:0]  unused_addr_s;

   // Byte-lane bits of the slave address carry no meaning for word registers.
   assign unused_addr_s = data_bus_addr[1:0];

   // Slave decode and control strobes.
   always_comb begin
      reg_sel_s = data_bus_addr[3:2];
      hit_s     = data_bus_select && (data_bus_addr[31:4] == BASE_ADDR[31:4]);
      bus_wr_s  = hit_s && (data_bus_mode == MODE_WR);
      bus_rd_s  = hit_s && (data_bus_mode == MODE_RD);
      busy_s    = (state_q != S_IDLE);
      start_s   = bus_wr_s && (reg_sel_s == 2'd3) && data_bus_write[0] && !busy_s;
      abort_s   = bus_wr_s && (reg_sel_s == 2'd3) && data_bus_write[4] && busy_s;
   end

   // Register readback.
   always_comb begin
      data_bus_read = 32'h0000_0000;
      if (bus_rd_s) begin
         case (reg_sel_s)
            2'd0:    data_bus_read = src_q;
            2'd1:    data_bus_read = dst_q;
            2'd2:    data_bus_read = {16'h0000, len_q};
            2'd3:    data_bus_read = {27'h0000000, irq_en_q, done_q, busy_s, 1'b0};
            default: data_bus_read = 32'h0000_0000;
         endcase
      end else begin
         data_bus_read = 32'h0000_0000;
      end
   end

   // Next-state: register writes, transfer FSM, abort, and registered outputs.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      data_d    = data_q;
      irq_en_d  = irq_en_q;
      done_sw_s = done_q;

      if (bus_wr_s) begin
         case (reg_sel_s)
            2'd0: if (!busy_s) src_d = {data_bus_write[31:2], 2'b00}; else src_d = src_q;
            2'd1: if (!busy_s) dst_d = {data_bus_write[31:2], 2'b00}; else dst_d = dst_q;
            2'd2: if (!busy_s) len_d = data_bus_write[15:0]; else len_d = len_q;
            2'd3: begin
               irq_en_d = data_bus_write[3];
               if (data_bus_write[2]) done_sw_s = 1'b0; else done_sw_s = done_q;
            end
            default: src_d = src_q;
         endcase
      end else begin
         src_d = src_q;
      end

      // FSM sets of DONE are applied after the W1C so that set wins.
      done_d = done_sw_s;

      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               if (len_q != 16'd0) begin
                  done_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  done_d  = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ:     if (dma_grant) state_d = S_READ;    else state_d = S_REQ;
         S_READ:    if (dma_grant) state_d = S_CAPTURE; else state_d = S_READ;
         S_CAPTURE: begin
            data_d  = dma_read_data;
            src_d   = src_q + 32'd4;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (dma_grant) begin
               dst_d = dst_q + 32'd4;
               len_d = len_q - 16'd1;
               if (len_q == 16'd1) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               state_d = S_WRITE;
            end
         end
         S_GAP:   state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase

      // Abort keeps SRC/DST/LEN as they are, except that a granted WRITE in
      // the same cycle still retires; DONE is never set by an aborted run.
      if (abort_s) begin
         state_d = S_IDLE;
         done_d  = done_sw_s;
         if (state_q != S_WRITE) src_d = src_q; else src_d = src_d;
      end else begin
         state_d = state_d;
      end

      // Outputs are registered, so they are derived from the next state.
      req_d   = 1'b0;
      mode_d  = MODE_NONE;
      addr_d  = 32'h0000_0000;
      wdata_d = 32'h0000_0000;
      case (state_d)
         S_REQ:     req_d = 1'b1;
         S_READ:    begin req_d = 1'b1; mode_d = MODE_RD; addr_d = src_d; end
         S_CAPTURE: req_d = 1'b1;
         S_WRITE:   begin req_d = 1'b1; mode_d = MODE_WR; addr_d = dst_d; wdata_d = data_d; end
         default:   req_d = 1'b0;
      endcase
      irq_d = done_d & irq_en_d;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         src_q    <= 32'h0000_0000;
         dst_q    <= 32'h0000_0000;
         len_q    <= 16'h0000;
         data_q   <= 32'h0000_0000;
         done_q   <= 1'b0;
         irq_en_q <= 1'b0;
         req_q    <= 1'b0;
         mode_q   <= MODE_NONE;
         addr_q   <= 32'h0000_0000;
         wdata_q  <= 32'h0000_0000;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         data_q   <= data_d;
         done_q   <= done_d;
         irq_en_q <= irq_en_d;
         req_q    <= req_d;
         mode_q   <= mode_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         irq_q    <= irq_d;
      end
   end

   assign dma_req        = req_q;
   assign dma_mode       = mode_q;
   assign dma_address    = addr_q;
   assign dma_write_data = wdata_q;
   assign dma_irq        = irq_q;
   assign dma_reqw       = 2'b10;

endmodule

// File: tb/tb_dma_controller.sv
// -----------------------------------------------------------------------------
// tb_dma_controller
// Self-checking bench for dma_controller: register table, scoreboarded copies
// (grant tied high and toggling), zero-length start, address wrap, abort and
// reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_dma_controller;

   localparam logic [31:0] BASE = 32'h0000_40E0;
   localparam logic [31:0] A_SRC = BASE + 32'h0;
   localparam logic [31:0] A_DST = BASE + 32'h4;
   localparam logic [31:0] A_LEN = BASE + 32'h8;
   localparam logic [31:0] A_CTL = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        data_bus_select = 1'b0;
   logic [31:0] data_bus_addr = 32'h0;
   logic [1:0]  data_bus_mode = 2'b00;
   logic [31:0] data_bus_write = 32'h0;
   logic [31:0] data_bus_read;
   logic        dma_req;
   logic        dma_grant = 1'b1;
   logic [31:0] dma_address;
   logic [1:0]  dma_mode;
   logic [1:0]  dma_reqw;
   logic [31:0] dma_write_data;
   logic [31:0] dma_read_data = 32'h0;
   logic        dma_irq;

   dma_controller dut (
      .clk(clk), .reset(reset),
      .data_bus_select(data_bus_select), .data_bus_addr(data_bus_addr),
      .data_bus_mode(data_bus_mode), .data_bus_write(data_bus_write),
      .data_bus_read(data_bus_read),
      .dma_req(dma_req), .dma_grant(dma_grant), .dma_address(dma_address),
      .dma_mode(dma_mode), .dma_reqw(dma_reqw), .dma_write_data(dma_write_data),
      .dma_read_data(dma_read_data), .dma_irq(dma_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // grant pattern: 0 = tied high, 1 = toggle every cycle
   int gmode = 0;
   bit mon_en = 1'b0;

   logic [31:0] exp_rd[$];
   logic [63:0] exp_wr[$];
   logic [31:0] obs_rd[$];
   logic [63:0] obs_wr[$];
   int hold_bad = 0;
   int gaps_seen = 0;
   int gap_bad = 0;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory/arbiter model and bus monitor, evaluated mid-cycle.
   initial begin : monitor
      bit          rd_pend = 1'b0;
      logic [31:0] rd_pend_addr = 32'h0;
      logic [1:0]  prev_mode = 2'b00;
      logic        prev_grant = 1'b1;
      logic [31:0] prev_addr = 32'h0;
      bit          seen_high = 1'b0;
      int          low_run = 0;
      forever begin
         @(negedge clk);
         if (gmode == 0) dma_grant = 1'b1; else dma_grant = ~dma_grant;
         if (rd_pend) dma_read_data = pat(rd_pend_addr); else dma_read_data = 32'hDEAD_BEEF;
         rd_pend = 1'b0;
         if (dma_grant && dma_mode == 2'b01) begin
            rd_pend = 1'b1;
            rd_pend_addr = dma_address;
            obs_rd.push_back(dma_address);
         end
         if (dma_grant && dma_mode == 2'b10) obs_wr.push_back({dma_address, dma_write_data});
         if (prev_mode != 2'b00 && !prev_grant && (dma_mode != prev_mode || dma_address != prev_addr))
            hold_bad++;
         prev_mode = dma_mode; prev_grant = dma_grant; prev_addr = dma_address;
         if (!mon_en) begin
            seen_high = 1'b0; low_run = 0;
         end else if (dma_req) begin
            if (seen_high && low_run > 0) begin
               gaps_seen++;
               if (low_run != 1) gap_bad++;
            end
            seen_high = 1'b1; low_run = 0;
         end else if (seen_high) begin
            low_run++;
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      data_bus_select = 1'b1; data_bus_mode = 2'b10; data_bus_addr = a; data_bus_write = d;
      @(negedge clk);
      data_bus_select = 1'b0; data_bus_mode = 2'b00; data_bus_addr = 32'h0; data_bus_write = 32'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      data_bus_select = 1'b1; data_bus_mode = 2'b01; data_bus_addr = a;
      #1;
      d = data_bus_read;
      data_bus_select = 1'b0; data_bus_mode = 2'b00; data_bus_addr = 32'h0;
   endtask

   task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(a, v);
      chk(name, v, exp);
   endtask

   task automatic plan_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(s + 32'(4 * i));
         exp_wr.push_back({d + 32'(4 * i), pat(s + 32'(4 * i))});
      end
   endtask

   task automatic compare_sb(input string name);
      while (exp_rd.size() > 0) begin
         logic [31:0] e;
         e = exp_rd.pop_front();
         if (obs_rd.size() == 0) chk({name, "_rd_missing"}, 32'hFFFF_FFFF, e);
         else chk({name, "_rd_addr"}, obs_rd.pop_front(), e);
      end
      while (exp_wr.size() > 0) begin
         logic [63:0] e;
         logic [63:0] o;
         e = exp_wr.pop_front();
         if (obs_wr.size() == 0) begin
            chk({name, "_wr_missing"}, 32'hFFFF_FFFF, e[63:32]);
         end else begin
            o = obs_wr.pop_front();
            chk({name, "_wr_addr"}, o[63:32], e[63:32]);
            chk({name, "_wr_data"}, o[31:0], e[31:0]);
         end
      end
      chk({name, "_extra_rd"}, 32'(obs_rd.size()), 32'd0);
      chk({name, "_extra_wr"}, 32'(obs_wr.size()), 32'd0);
   endtask

   // Polls CTRL each cycle from cycle 1 after START until DONE is seen.
   task automatic wait_done(input string name, input int bound, output int busy_cnt, output int irq_cyc);
      logic [31:0] c;
      bit          seen = 1'b0;
      busy_cnt = 0;
      irq_cyc = -1;
      for (int k = 1; k <= bound; k++) begin
         bus_read(A_CTL, c);
         if (c[1]) busy_cnt++;
         if (dma_irq && irq_cyc < 0) irq_cyc = k;
         if (c[2]) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   initial begin : main
      vec_t        tbl[6];
      logic [31:0] v;
      int          busy_cnt, irq_cyc, g0, r0;
      bit          found;

      tbl[0] = '{A_SRC,                 32'h0000_1003, 32'h0000_1000};
      tbl[1] = '{A_DST,                 32'hFFFF_FFFE, 32'hFFFF_FFFC};
      tbl[2] = '{A_LEN,                 32'hABCD_1234, 32'h0000_1234};
      tbl[3] = '{A_CTL,                 32'h0000_0008, 32'h0000_0008};
      tbl[4] = '{BASE + 32'h10,         32'h5555_5555, 32'h0000_0000};
      tbl[5] = '{BASE + 32'hE,          32'h0000_0000, 32'h0000_0000};

      // reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_req", {31'd0, dma_req}, 32'd0);
      chk("rst_mode", {30'd0, dma_mode}, 32'd0);
      chk("rst_addr", dma_address, 32'd0);
      chk("rst_wdata", dma_write_data, 32'd0);
      chk("rst_irq", {31'd0, dma_irq}, 32'd0);
      chk("reqw", {30'd0, dma_reqw}, 32'd2);
      chk_reg("rst_src", A_SRC, 32'd0);
      chk_reg("rst_dst", A_DST, 32'd0);
      chk_reg("rst_len", A_LEN, 32'd0);
      chk_reg("rst_ctl", A_CTL, 32'd0);

      // register table
      for (int i = 0; i < 6; i++) begin
         bus_write(tbl[i].addr, tbl[i].wdata);
         bus_read(tbl[i].addr, v);
         chk($sformatf("reg_tbl%0d", i), v, tbl[i].exp);
      end
      data_bus_select = 1'b1; data_bus_mode = 2'b00; data_bus_addr = A_SRC;
      #1 chk("rd_mode_none", data_bus_read, 32'd0);
      data_bus_select = 1'b0; data_bus_mode = 2'b01;
      #1 chk("rd_no_select", data_bus_read, 32'd0);
      data_bus_mode = 2'b00; data_bus_addr = 32'h0;
      @(negedge clk);

      // 4-word copy, grant tied high, IRQ enabled
      bus_write(A_SRC, 32'h0000_1000);
      bus_write(A_DST, 32'h0000_2000);
      bus_write(A_LEN, 32'd4);
      bus_write(A_CTL, 32'h0000_0008);
      plan_copy(32'h0000_1000, 32'h0000_2000, 4);
      g0 = gaps_seen;
      mon_en = 1'b1;
      bus_write(A_CTL, 32'h0000_0009);
      wait_done("copy4", 200, busy_cnt, irq_cyc);
      mon_en = 1'b0;
      chk("copy4_irq_cycle", 32'(irq_cyc), 32'd20);
      chk("copy4_busy_cycles", 32'(busy_cnt), 32'd19);
      chk_reg("copy4_src", A_SRC, 32'h0000_1010);
      chk_reg("copy4_dst", A_DST, 32'h0000_2010);
      chk_reg("copy4_len", A_LEN, 32'd0);
      chk("copy4_gaps", 32'(gaps_seen - g0), 32'd3);
      compare_sb("copy4");
      bus_write(A_CTL, 32'h0000_000C);
      chk("w1c_irq", {31'd0, dma_irq}, 32'd0);
      chk_reg("w1c_ctl", A_CTL, 32'h0000_0008);

      // 3-word copy with grant toggling
      gmode = 1;
      bus_write(A_SRC, 32'h0000_1100);
      bus_write(A_DST, 32'h0000_2200);
      bus_write(A_LEN, 32'd3);
      plan_copy(32'h0000_1100, 32'h0000_2200, 3);
      g0 = gaps_seen;
      mon_en = 1'b1;
      bus_write(A_CTL, 32'h0000_0001);
      wait_done("toggle", 300, busy_cnt, irq_cyc);
      mon_en = 1'b0;
      gmode = 0;
      chk("toggle_gaps", 32'(gaps_seen - g0), 32'd2);
      chk_reg("toggle_len", A_LEN, 32'd0);
      compare_sb("toggle");

      // START with LEN=0
      bus_write(A_CTL, 32'h0000_0004);
      bus_write(A_LEN, 32'd0);
      r0 = obs_rd.size();
      bus_write(A_CTL, 32'h0000_0001);
      chk_reg("len0_done", A_CTL, 32'h0000_0004);
      chk("len0_req", {31'd0, dma_req}, 32'd0);
      repeat (3) @(negedge clk);
      chk("len0_no_cycles", 32'(obs_rd.size() - r0), 32'd0);

      // source address wrap
      bus_write(A_CTL, 32'h0000_0004);
      bus_write(A_SRC, 32'hFFFF_FFFC);
      bus_write(A_DST, 32'h0000_3000);
      bus_write(A_LEN, 32'd2);
      plan_copy(32'hFFFF_FFFC, 32'h0000_3000, 2);
      bus_write(A_CTL, 32'h0000_0001);
      wait_done("wrap", 100, busy_cnt, irq_cyc);
      chk_reg("wrap_src", A_SRC, 32'h0000_0004);
      chk_reg("wrap_dst", A_DST, 32'h0000_3008);
      compare_sb("wrap");

      // abort during READ of word 2 of 5, with ignored writes while busy
      bus_write(A_CTL, 32'h0000_0004);
      bus_write(A_SRC, 32'h0000_5000);
      bus_write(A_DST, 32'h0000_6000);
      bus_write(A_LEN, 32'd5);
      exp_rd.push_back(32'h0000_5000);
      exp_rd.push_back(32'h0000_5004);
      exp_wr.push_back({32'h0000_6000, pat(32'h0000_5000)});
      bus_write(A_CTL, 32'h0000_0001);
      bus_write(A_SRC, 32'h0000_9990);
      bus_write(A_CTL, 32'h0000_0001);
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (dma_mode == 2'b01 && dma_address == 32'h0000_5004) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("abort_reach_read2", {31'd0, found}, 32'd1);
      bus_write(A_CTL, 32'h0000_0010);
      chk_reg("abort_ctl", A_CTL, 32'h0000_0000);
      chk_reg("abort_len", A_LEN, 32'd4);
      chk_reg("abort_src", A_SRC, 32'h0000_5004);
      chk_reg("abort_dst", A_DST, 32'h0000_6004);
      chk("abort_req", {31'd0, dma_req}, 32'd0);
      compare_sb("abort");

      // reset during WRITE
      bus_write(A_SRC, 32'h0000_7000);
      bus_write(A_DST, 32'h0000_8000);
      bus_write(A_LEN, 32'd3);
      bus_write(A_CTL, 32'h0000_0009);
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (dma_mode == 2'b10) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("rstw_reach_write", {31'd0, found}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstw_req", {31'd0, dma_req}, 32'd0);
      chk("rstw_mode", {30'd0, dma_mode}, 32'd0);
      chk("rstw_addr", dma_address, 32'd0);
      chk("rstw_wdata", dma_write_data, 32'd0);
      chk("rstw_irq", {31'd0, dma_irq}, 32'd0);
      chk_reg("rstw_src", A_SRC, 32'd0);
      chk_reg("rstw_dst", A_DST, 32'd0);
      chk_reg("rstw_len", A_LEN, 32'd0);
      chk_reg("rstw_ctl", A_CTL, 32'd0);
      obs_rd.delete();
      obs_wr.delete();

      chk("hold_while_ungranted", 32'(hold_bad), 32'd0);
      chk("gap_exactly_one", 32'(gap_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
